// File: rtl/alu_seq_control_pkg.sv
// ----------------------------------------------------------------------------
// alu_seq_control_pkg: shared ALU control codes, AluOp classes, opcodes and FSM states.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package alu_seq_control_pkg;

  localparam logic [1:0] c_aluop_mem   = 2'b00;
  localparam logic [1:0] c_aluop_br    = 2'b01;
  localparam logic [1:0] c_aluop_rtype = 2'b10;
  localparam logic [1:0] c_aluop_opc   = 2'b11;

  localparam logic [3:0] c_fn_and = 4'b0000;
  localparam logic [3:0] c_fn_or  = 4'b0001;
  localparam logic [3:0] c_fn_add = 4'b0010;
  localparam logic [3:0] c_fn_xor = 4'b0011;
  localparam logic [3:0] c_fn_nor = 4'b0100;
  localparam logic [3:0] c_fn_slt = 4'b0110;
  localparam logic [3:0] c_fn_sub = 4'b0111;

  localparam logic [3:0] c_aluc_and     = 4'b0000;
  localparam logic [3:0] c_aluc_or      = 4'b0001;
  localparam logic [3:0] c_aluc_add     = 4'b0010;
  localparam logic [3:0] c_aluc_nor     = 4'b0011;
  localparam logic [3:0] c_aluc_mul     = 4'b0100;
  localparam logic [3:0] c_aluc_slt     = 4'b0101;
  localparam logic [3:0] c_aluc_sub     = 4'b0110;
  localparam logic [3:0] c_aluc_xor     = 4'b1010;
  localparam logic [3:0] c_aluc_illegal = 4'b1111;

  localparam logic [3:0] c_opc_mul = 4'b0110;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [3:0] c_opc_div  = 4'b0111;
  localparam logic [3:0] c_aluc_div = 4'b0111;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
`ifdef ALU_SEQ_DIV_EN
    S_DIV  = 2'b10,
`endif
    S_DONE = 2'b11
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_seq_control_iter_muldiv.sv
// ----------------------------------------------------------------------------
// iter_muldiv: one-bit-per-cycle unsigned shift-add multiplier / restoring divider
// (divider present only with ALU_SEQ_DIV_EN).  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module iter_muldiv
  import alu_seq_control_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
`ifdef ALU_SEQ_DIV_EN
  input  logic             i_div,
  input  logic             i_div0,
`endif
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi,
  output logic             o_last
);

  localparam int CNTW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [CNTW-1:0]  r_cnt;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
`ifdef ALU_SEQ_DIV_EN
  logic             r_div;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
`endif

  // Multiply: {hi,lo} starts as {0,B}; conditionally add A into hi, then shift right.
  // Divide: {rem,quot} starts as {0,A}; shift left and subtract B when it fits.
  always_comb begin
    w_sum    = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_opnd}) : {1'b0, r_hi};
    w_hi_nxt = w_sum[WIDTH:1];
    w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
    w_shift = {r_hi, r_lo[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_opnd};
    if (r_div) begin
      // Borrow in the top bit means the trial subtraction does not fit.
      w_hi_nxt = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_opnd <= '0;
      r_lo   <= '0;
      r_hi   <= '0;
      r_cnt  <= '0;
`ifdef ALU_SEQ_DIV_EN
      r_div  <= 1'b0;
`endif
    end else if (i_load) begin
      r_cnt  <= '0;
      r_hi   <= '0;
      r_opnd <= i_a;
      r_lo   <= i_b;
`ifdef ALU_SEQ_DIV_EN
      r_div  <= i_div;
      if (i_div) begin
        r_opnd <= i_b;
        r_lo   <= i_a;
      end
      if (i_div0) begin
        r_lo <= '1;
        r_hi <= i_a;
      end
`endif
    end else if (i_step) begin
      r_cnt <= r_cnt + CNTW'(1);
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
    end
  end

  assign o_lo   = r_lo;
  assign o_hi   = r_hi;
  assign o_last = (r_cnt == CNTW'(WIDTH - 1));

endmodule

`default_nettype wire

// File: rtl/alu_seq_control.sv
// ----------------------------------------------------------------------------
// alu_seq_control: ALU control decode plus sequencing FSM for multicycle MUL/DIV;
// DIV support enabled by defining ALU_SEQ_DIV_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_seq_control
  import alu_seq_control_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int FUNCW = 4,
  parameter int OPW   = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [1:0]       AluOp,
  input  logic [FUNCW-1:0] Function,
  input  logic [OPW-1:0]   opcode,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [3:0]       ALUContr,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic             Illegal
);

  state_t r_state;
  logic   r_done;
  logic   w_is_mul;
  logic   w_is_div;
  logic   w_busy;
  logic   w_accept;
  logic   w_last;
`ifdef ALU_SEQ_DIV_EN
  logic   w_div0;
`endif

  always_comb begin
    ALUContr = c_aluc_illegal;
    Illegal  = 1'b1;
    w_is_mul = 1'b0;
    w_is_div = 1'b0;
    case (AluOp)
      c_aluop_mem: begin ALUContr = c_aluc_add; Illegal = 1'b0; end
      c_aluop_br:  begin ALUContr = c_aluc_sub; Illegal = 1'b0; end
      c_aluop_rtype: begin
        Illegal = 1'b0;
        case (Function)
          FUNCW'(c_fn_and): ALUContr = c_aluc_and;
          FUNCW'(c_fn_or):  ALUContr = c_aluc_or;
          FUNCW'(c_fn_add): ALUContr = c_aluc_add;
          FUNCW'(c_fn_xor): ALUContr = c_aluc_xor;
          FUNCW'(c_fn_nor): ALUContr = c_aluc_nor;
          FUNCW'(c_fn_slt): ALUContr = c_aluc_slt;
          FUNCW'(c_fn_sub): ALUContr = c_aluc_sub;
          default:          Illegal  = 1'b1;
        endcase
      end
      c_aluop_opc: begin
        if (opcode == OPW'(c_opc_mul)) begin
          ALUContr = c_aluc_mul;
          Illegal  = 1'b0;
          w_is_mul = 1'b1;
        end
`ifdef ALU_SEQ_DIV_EN
        else if (opcode == OPW'(c_opc_div)) begin
          ALUContr = c_aluc_div;
          Illegal  = 1'b0;
          w_is_div = 1'b1;
        end
`endif
      end
    endcase
  end

  always_comb begin
    w_busy = (r_state == S_MUL);
`ifdef ALU_SEQ_DIV_EN
    w_busy = w_busy || (r_state == S_DIV);
`endif
  end

  // Starts are only taken while no iteration is in flight; Reset wins over Start.
  assign w_accept = Start && !Reset && !w_busy && (w_is_mul || w_is_div);
`ifdef ALU_SEQ_DIV_EN
  assign w_div0   = w_is_div && (B == '0);
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_MUL: if (w_last) begin r_state <= S_DONE; r_done <= 1'b1; end
`ifdef ALU_SEQ_DIV_EN
        S_DIV: if (w_last) begin r_state <= S_DONE; r_done <= 1'b1; end
`endif
        default: begin
          if (w_accept) begin
            r_state <= S_MUL;
`ifdef ALU_SEQ_DIV_EN
            if (w_div0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (w_is_div) begin
              r_state <= S_DIV;
            end
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign Stall = w_accept || w_busy;
  assign Done  = r_done;

  iter_muldiv #(
    .WIDTH (WIDTH)
  ) u_iter_muldiv (
    .clk    (Clock),
    .rst    (Reset),
    .i_load (w_accept),
`ifdef ALU_SEQ_DIV_EN
    .i_div  (w_is_div),
    .i_div0 (w_div0),
`endif
    .i_step (w_busy),
    .i_a    (A),
    .i_b    (B),
    .o_lo   (Result),
    .o_hi   (ResultHi),
    .o_last (w_last)
  );

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_control.sv
// ----------------------------------------------------------------------------
// tb_alu_seq_control: randomized scoreboard bench for alu_seq_control (WIDTH=24).
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_alu_seq_control;

  localparam int W = 24;
`ifdef ALU_SEQ_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic         Start = 1'b0;
  logic [1:0]   AluOp = 2'b00;
  logic [3:0]   Function = 4'h0;
  logic [3:0]   opcode = 4'h0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [3:0]   ALUContr;
  logic         Stall;
  logic         Done;
  logic [W-1:0] Result;
  logic [W-1:0] ResultHi;
  logic         Illegal;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    int           done_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   pend_done = -1;

  alu_seq_control #(.WIDTH(W), .FUNCW(4), .OPW(4)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .AluOp    (AluOp),
    .Function (Function),
    .opcode   (opcode),
    .Start    (Start),
    .A        (A),
    .B        (B),
    .ALUContr (ALUContr),
    .Stall    (Stall),
    .Done     (Done),
    .Result   (Result),
    .ResultHi (ResultHi),
    .Illegal  (Illegal)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decode table: {Illegal, ALUContr}
  function automatic logic [4:0] ref_decode(input logic [1:0] op, input logic [3:0] f,
                                            input logic [3:0] opc);
    logic [4:0] r;
    r = 5'h1F;
    if (op == 2'd0) r = 5'h02;
    else if (op == 2'd1) r = 5'h06;
    else if (op == 2'd2) begin
      case (f)
        4'h0: r = 5'h00;
        4'h1: r = 5'h01;
        4'h2: r = 5'h02;
        4'h3: r = 5'h0A;
        4'h4: r = 5'h03;
        4'h6: r = 5'h05;
        4'h7: r = 5'h06;
        default: r = 5'h1F;
      endcase
    end else begin
      if (opc == 4'h6) r = 5'h04;
      else if (DIV_EN && opc == 4'h7) r = 5'h07;
    end
    return r;
  endfunction

  function automatic bit is_div_op(input logic [1:0] op, input logic [3:0] opc);
    return DIV_EN && op == 2'd3 && opc == 4'h7;
  endfunction

  function automatic bit is_mc(input logic [1:0] op, input logic [3:0] opc);
    return (op == 2'd3 && opc == 4'h6) || is_div_op(op, opc);
  endfunction

  task automatic drive(input logic s, input logic [1:0] op, input logic [3:0] f,
                       input logic [3:0] opc, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [4:0]     d;
    logic           busy;
    logic           acc;
    int             s_cyc;
    logic [2*W-1:0] p;
    exp_t           e;
    Start = s; AluOp = op; Function = f; opcode = opc; A = a; B = b;
    @(negedge Clock);
    s_cyc = cyc;
    d     = ref_decode(op, f, opc);
    busy  = (pend_done > s_cyc);
    acc   = s && is_mc(op, opc) && !busy;
    check("alu_contr", 64'(ALUContr), 64'(d[3:0]));
    check("illegal", 64'(Illegal), 64'(d[4]));
    check("stall", 64'(Stall), 64'(acc || busy));
    @(posedge Clock);
    if (acc) begin
      if (is_div_op(op, opc)) begin
        if (b == '0) begin
          e.lo = '1; e.hi = a; e.done_cyc = s_cyc + 1;
        end else begin
          e.lo = a / b; e.hi = a % b; e.done_cyc = s_cyc + W + 1;
        end
      end else begin
        p = (2*W)'(a) * (2*W)'(b);
        e.lo = p[W-1:0]; e.hi = p[2*W-1:W]; e.done_cyc = s_cyc + W + 1;
      end
      pend_done = e.done_cyc;
      sb.push_back(e);
    end
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 4'h0, 4'h0, '0, '0);
  endtask

  task automatic idle_through_done();
    while (cyc <= pend_done) idle();
  endtask

  task automatic reset_pulse();
    Reset = 1'b1; Start = 1'b1; AluOp = 2'd3; opcode = 4'h6; A = 24'h000123; B = 24'h000456;
    @(posedge Clock);
    sb.delete();
    pend_done = -1;
    #1;
    Reset = 1'b0; Start = 1'b0;
    @(negedge Clock);
    check("rst_result", 64'(Result), 64'h0);
    check("rst_result_hi", 64'(ResultHi), 64'h0);
    check("rst_done", 64'(Done), 64'h0);
    check("rst_stall", 64'(Stall), 64'h0);
    @(posedge Clock);
    #1;
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation, on time.
  always @(negedge Clock) begin
    exp_t e;
    if (!Reset) begin
      if (Done) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: got Done=1, expected Done=0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("result", 64'(Result), 64'(e.lo));
          check("result_hi", 64'(ResultHi), 64'(e.hi));
          check("done_cycle", 64'(cyc), 64'(e.done_cyc));
        end
      end else if (sb.size() != 0 && cyc >= sb[0].done_cyc) begin
        e = sb.pop_front();
        n_checks++; n_fail++;
        $display("FAIL missing_done: got Done=0, expected Done=1 at cycle %0d", e.done_cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge Clock);
    #1;
    check("reset_result", 64'(Result), 64'h0);
    check("reset_result_hi", 64'(ResultHi), 64'h0);
    check("reset_done", 64'(Done), 64'h0);
    check("reset_stall", 64'(Stall), 64'h0);
    Reset = 1'b0;

    drive(1'b1, 2'd2, 4'h3, 4'h0, 24'd9, 24'd9);
    drive(1'b1, 2'd2, 4'hF, 4'h0, 24'd1, 24'd1);
    drive(1'b1, 2'd0, 4'h0, 4'h6, 24'd1, 24'd1);
    drive(1'b1, 2'd1, 4'h0, 4'h6, 24'd1, 24'd1);

    drive(1'b1, 2'd3, 4'h0, 4'h6, 24'd3, 24'd5);
    drive(1'b1, 2'd3, 4'h0, 4'h6, 24'd7, 24'd7);
    idle_through_done();

    drive(1'b1, 2'd3, 4'h0, 4'h6, 24'hFFFFFF, 24'hFFFFFF);
    while (cyc < pend_done) idle();
    drive(1'b1, 2'd3, 4'h0, 4'h6, 24'h123456, 24'hABCDEF);
    idle_through_done();

    drive(1'b1, 2'd3, 4'h0, 4'h7, 24'd100, 24'd7);
    idle_through_done();
    drive(1'b1, 2'd3, 4'h0, 4'h7, 24'd100, 24'd0);
    drive(1'b1, 2'd3, 4'h0, 4'h7, 24'hFFFFFF, 24'd0);
    idle_through_done();
    idle();

    drive(1'b1, 2'd3, 4'h0, 4'h6, 24'h00BEEF, 24'h000F0F);
    repeat (10) idle();
    reset_pulse();
    repeat (30) idle();

    for (int i = 0; i < 400; i++) begin
      logic         s;
      logic [1:0]   op;
      logic [3:0]   f;
      logic [3:0]   opc;
      logic [W-1:0] a;
      logic [W-1:0] b;
      s   = ($urandom_range(0, 2) == 0);
      op  = ($urandom_range(0, 1) == 1) ? 2'd3 : 2'($urandom_range(0, 3));
      f   = 4'($urandom);
      opc = ($urandom_range(0, 2) != 0) ? (4'h6 + 4'($urandom_range(0, 1))) : 4'($urandom);
      a   = W'($urandom);
      b   = ($urandom_range(0, 5) == 0) ? '0 : (W'($urandom) >> $urandom_range(0, 20));
      drive(s, op, f, opc, a, b);
    end

    idle_through_done();
    repeat (3) idle();
    check("scoreboard_empty", 64'(sb.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
